// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 slice: widths, opcode encoding and helpers.
package alu32_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_SHR = 4'h8,
        OP_SHL = 4'h9,
        OP_EQ  = 4'hA,
        OP_NEQ = 4'hB,
        OP_GT  = 4'hC,
        OP_LT  = 4'hD
    } op_e;

    // Compare results are a full-width word holding 0 or 1.
    function automatic logic [DATA_W-1:0] bool_word(input logic b);
        return {{(DATA_W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/alu32_shifter.sv
// Logical left/right barrel shift of a data word by a 5-bit amount.
module alu32_shifter
    import alu32_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shl,
    output logic [DATA_W-1:0]  result
);

    always_comb begin
        result = '0;
        if (shl) begin
            result = data << shamt;
        end else begin
            result = data >> shamt;
        end
    end

endmodule

// File: rtl/alu32.sv
// Single-cycle registered 32-bit ALU. MUL/DIV hardware is present only when
// the macro ALU_MULDIV_EN is defined; otherwise those opcodes return zero.
module alu32
    import alu32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry_out,
    output logic              borrow_out
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] res_d;
    logic              carry_d;
    logic              borrow_d;

    assign sum = {1'b0, X} + {1'b0, Y};

    alu32_shifter u_shifter (
        .data   (X),
        .shamt  (Y[SHAMT_W-1:0]),
        .shl    (sel == OP_SHL),
        .result (shift_res)
    );

    // Unlisted and X/Z opcodes match no case item and fall to the zero default.
    always_comb begin
        res_d    = '0;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        case (sel)
            OP_ADD: begin
                res_d   = sum[DATA_W-1:0];
                carry_d = sum[DATA_W];
            end
            OP_SUB: begin
                res_d    = X - Y;
                borrow_d = (X < Y);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: res_d = X * Y;
            OP_DIV: res_d = (Y == '0) ? '1 : (X / Y);
`endif
            OP_AND: res_d = X & Y;
            OP_OR:  res_d = X | Y;
            OP_XOR: res_d = X ^ Y;
            OP_NOT: res_d = ~X;
            OP_SHR: res_d = shift_res;
            OP_SHL: res_d = shift_res;
            OP_EQ:  res_d = bool_word(X == Y);
            OP_NEQ: res_d = bool_word(X != Y);
            OP_GT:  res_d = bool_word(X > Y);
            OP_LT:  res_d = bool_word(X < Y);
            default: begin
                res_d    = '0;
                carry_d  = 1'b0;
                borrow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out    <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            alu_out    <= res_d;
            carry_out  <= carry_d;
            borrow_out <= borrow_d;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Directed self-checking bench for alu32; MUL/DIV expectations follow ALU_MULDIV_EN.
module tb_alu32;

    logic        clk;
    logic        rst_n;
    logic [31:0] X;
    logic [31:0] Y;
    logic [3:0]  sel;
    logic [31:0] alu_out;
    logic        carry_out;
    logic        borrow_out;

    int unsigned tests;
    int unsigned fails;

    alu32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .X          (X),
        .Y          (Y),
        .sel        (sel),
        .alu_out    (alu_out),
        .carry_out  (carry_out),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_o,
                         input logic exp_c, input logic exp_b);
        tests++;
        assert ({alu_out, carry_out, borrow_out} === {exp_o, exp_c, exp_b})
        else begin
            fails++;
            $error("FAIL %s: observed out=%h c=%b b=%b, expected out=%h c=%b b=%b",
                   tag, alu_out, carry_out, borrow_out, exp_o, exp_c, exp_b);
        end
    endtask

    // Apply operands on the falling edge, then sample just after the next rising edge.
    task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sel = s;
        X   = a;
        Y   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        X     = '0;
        Y     = '0;
        sel   = 4'h0;

        #3 rst_n = 1'b0;
        #1 check("reset_state", 32'h0, 1'b0, 1'b0);
        X = 32'd5; Y = 32'd6;
        @(posedge clk); #1;
        check("reset_hold", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'h0, 32'd100, 32'd50);             check("add", 32'd150, 1'b0, 1'b0);
        run_op(4'h1, 32'd50, 32'd100);             check("sub_borrow", 32'hFFFFFFCE, 1'b0, 1'b1);
        run_op(4'h0, 32'hFFFFFFFF, 32'd1);         check("add_carry", 32'h0, 1'b1, 1'b0);
        run_op(4'h1, 32'd5, 32'd5);                check("sub_equal", 32'h0, 1'b0, 1'b0);
        run_op(4'h1, 32'd100, 32'd1);              check("sub_noborrow", 32'd99, 1'b0, 1'b0);
`ifdef ALU_MULDIV_EN
        run_op(4'h2, 32'd10, 32'd20);              check("mul", 32'd200, 1'b0, 1'b0);
        run_op(4'h2, 32'h00010000, 32'h00010001);  check("mul_wrap", 32'h00010000, 1'b0, 1'b0);
        run_op(4'h3, 32'd100, 32'd25);             check("div", 32'd4, 1'b0, 1'b0);
        run_op(4'h3, 32'd7, 32'd0);                check("div_zero", 32'hFFFFFFFF, 1'b0, 1'b0);
`else
        run_op(4'h2, 32'd10, 32'd20);              check("mul_off", 32'h0, 1'b0, 1'b0);
        run_op(4'h3, 32'd100, 32'd25);             check("div_off", 32'h0, 1'b0, 1'b0);
`endif
        run_op(4'h4, 32'hFFFF0000, 32'h0000FFFF);  check("and", 32'h0, 1'b0, 1'b0);
        run_op(4'h5, 32'hFFFF0000, 32'h0000FFFF);  check("or", 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(4'h6, 32'hAAAA5555, 32'h5555AAAA);  check("xor", 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(4'h7, 32'hFFFFFFFF, 32'h12345678);  check("not", 32'h0, 1'b0, 1'b0);
        run_op(4'h8, 32'hF0000000, 32'd4);         check("shr", 32'h0F000000, 1'b0, 1'b0);
        run_op(4'h9, 32'h0000000F, 32'd4);         check("shl", 32'h000000F0, 1'b0, 1'b0);
        run_op(4'h9, 32'h00000001, 32'h00000024);  check("shl_upper_y_ignored", 32'h00000010, 1'b0, 1'b0);
        run_op(4'h8, 32'h80000000, 32'd31);        check("shr_31", 32'h00000001, 1'b0, 1'b0);
        run_op(4'hA, 32'd1234, 32'd1234);          check("eq_true", 32'd1, 1'b0, 1'b0);
        run_op(4'hA, 32'd1234, 32'd1235);          check("eq_false", 32'd0, 1'b0, 1'b0);
        run_op(4'hB, 32'd1234, 32'd4321);          check("neq", 32'd1, 1'b0, 1'b0);
        run_op(4'hC, 32'd50, 32'd20);              check("gt_true", 32'd1, 1'b0, 1'b0);
        run_op(4'hC, 32'd10, 32'd100);             check("gt_false", 32'd0, 1'b0, 1'b0);
        run_op(4'hC, 32'h80000000, 32'd1);         check("gt_unsigned", 32'd1, 1'b0, 1'b0);
        run_op(4'hD, 32'd10, 32'd100);             check("lt", 32'd1, 1'b0, 1'b0);
        run_op(4'hE, 32'd1, 32'd1);                check("sel_e", 32'h0, 1'b0, 1'b0);
        run_op(4'hF, 32'hFFFFFFFF, 32'd1);         check("sel_f", 32'h0, 1'b0, 1'b0);
        run_op(4'bxxxx, 32'd0, 32'd0);             check("sel_x", 32'h0, 1'b0, 1'b0);

        // Output must not change until the edge after the operands are applied.
        run_op(4'hD, 32'd1, 32'd2);                check("lat_prev", 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        sel = 4'h0; X = 32'd3; Y = 32'd4;
        #1 check("lat_before_edge", 32'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("lat_after_edge", 32'd7, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, with an ADD in flight.
        run_op(4'h0, 32'hFFFFFFFF, 32'd2);         check("pre_reset", 32'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_low_edge", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("after_release", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("first_edge_after_release", 32'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
